// File: rtl/stq_part_pkg.sv
// Shared types and helpers for the store-queue partition reconfiguration controller.
`ifndef STRUCT_PARTS_LSQ
`define STRUCT_PARTS_LSQ 4
`endif
`ifndef STRUCT_PARTS_LSQ_LOG
`define STRUCT_PARTS_LSQ_LOG 2
`endif

package stq_part_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SCRUB  = 2'd2,
    ST_SETTLE = 2'd3
  } stq_part_state_e;

  // Wide enough for any tag width; users slice off what they need.
  localparam logic [63:0] SCRUB_TAG = {64{1'b1}};

  function automatic int unsigned partOf(input logic [31:0] addr,
                                         input int unsigned index_w,
                                         input int unsigned log_w);
    return (addr >> (index_w - log_w)) & ((32'd1 << log_w) - 32'd1);
  endfunction

endpackage

// File: rtl/stq_part_scrub_walker.sv
// Scrub walker: steps an index across every CAM entry once per start and
// raises a registered write enable for entries in partitions being added.
module stq_scrub_walker
  import stq_part_pkg::*;
#(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned INDEX         = 4,
  parameter int unsigned NUM_PARTS     = 4,
  parameter int unsigned NUM_PARTS_LOG = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [NUM_PARTS-1:0] scrub_mask_i,
  output logic [INDEX-1:0]     idx_o,
  output logic                 we_o,
  output logic                 done_o
);

  logic [INDEX-1:0]         idx_q, idx_d;
  logic                     busy_q, busy_d;
  logic                     we_q, we_d;
  logic [NUM_PARTS_LOG-1:0] part_d;

  // Next index, run flag and write qualification for the entry about to be shown
  always_comb begin
    idx_d  = idx_q;
    busy_d = busy_q;
    if (start_i) begin
      idx_d  = {INDEX{1'b0}};
      busy_d = 1'b1;
    end else if (busy_q) begin
      idx_d  = idx_q + INDEX'(1);
      busy_d = (idx_q != INDEX'(DEPTH - 1));
    end else begin
      idx_d  = idx_q;
      busy_d = 1'b0;
    end
    part_d = NUM_PARTS_LOG'(partOf(32'(idx_d), INDEX, NUM_PARTS_LOG));
    we_d   = busy_d & scrub_mask_i[part_d];
  end

  // Walker state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q  <= {INDEX{1'b0}};
      busy_q <= 1'b0;
      we_q   <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      busy_q <= busy_d;
      we_q   <= we_d;
    end
  end

  assign idx_o  = idx_q;
  assign we_o   = we_q;
  assign done_o = busy_q & (idx_q == INDEX'(DEPTH - 1));

endmodule

// File: rtl/stq_partition_reconfig_ctrl.sv
// Run-time active-partition reconfiguration for the partitioned STQ CAM.
// Define STQ_PART_SCRUB_EN to scrub newly added partitions before publishing.
module stq_partition_reconfig_ctrl
  import stq_part_pkg::*;
#(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned INDEX         = 4,
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned NUM_PARTS     = `STRUCT_PARTS_LSQ,
  parameter int unsigned NUM_PARTS_LOG = `STRUCT_PARTS_LSQ_LOG,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reqValid_i,
  input  logic [NUM_PARTS-1:0] reqMask_i,
  output logic                 reqReady_o,
  input  logic [DEPTH-1:0]     stqOccupied_i,
  input  logic                 dispWe_i,
  input  logic [INDEX-1:0]     dispAddr_i,
  input  logic [WIDTH-1:0]     dispData_i,
  output logic                 camWe_o,
  output logic [INDEX-1:0]     camAddr_o,
  output logic [WIDTH-1:0]     camData_o,
  output logic [NUM_PARTS-1:0] lsqPartitionActive_o,
  output logic                 stallDispatch_o,
  output logic                 reconfigDone_o,
  output logic                 reqError_o
);

  localparam int unsigned PART_SIZE = DEPTH / NUM_PARTS;

  stq_part_state_e          state_q, state_d;
  logic [NUM_PARTS-1:0]     active_q, active_d;
  logic [NUM_PARTS-1:0]     new_q, new_d;
  logic [NUM_PARTS-1:0]     drain_q, drain_d;
  logic [NUM_PARTS-1:0]     scrub_q, scrub_d;
  logic [3:0]               settle_q, settle_d;
  logic                     ready_q, ready_d;
  logic                     stall_q, stall_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [NUM_PARTS-1:0]     occ_part_s;
  logic                     drain_busy_s;
  logic                     accept_s;
  logic                     scrub_start_s;
  logic                     scrub_done_s;
  logic                     scrub_we_s;
  logic [INDEX-1:0]         scrub_idx_s;
  logic [NUM_PARTS_LOG-1:0] disp_part_s;

  // Per-partition "still holds a store" summary
  always_comb begin
    for (int p = 0; p < int'(NUM_PARTS); p++) begin
      occ_part_s[p] = |stqOccupied_i[p*PART_SIZE +: PART_SIZE];
    end
    drain_busy_s = |(occ_part_s & drain_q);
  end

  // Sequencer next-state logic
  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    new_d         = new_q;
    drain_d       = drain_q;
    scrub_d       = scrub_q;
    settle_d      = settle_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    scrub_start_s = 1'b0;
    accept_s      = reqValid_i & ready_q;
    case (state_q)
      ST_IDLE: begin
        if (!accept_s) begin
          state_d = ST_IDLE;
        end else if (reqMask_i == {NUM_PARTS{1'b0}}) begin
          err_d = 1'b1;
        end else if (reqMask_i == active_q) begin
          done_d = 1'b1;
        end else begin
          new_d   = reqMask_i;
          drain_d = active_q & ~reqMask_i;
          scrub_d = reqMask_i & ~active_q;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!drain_busy_s) begin
`ifdef STQ_PART_SCRUB_EN
          scrub_start_s = 1'b1;
          state_d       = ST_SCRUB;
`else
          settle_d = 4'd0;
          state_d  = ST_SETTLE;
`endif
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_SCRUB: begin
        if (scrub_done_s) begin
          settle_d = 4'd0;
          state_d  = ST_SETTLE;
        end else begin
          state_d = ST_SCRUB;
        end
      end
      ST_SETTLE: begin
        if (settle_q == 4'(SETTLE_CYCLES - 1)) begin
          active_d = new_q;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    stall_d = (state_d != ST_IDLE);
  end

  // Sequencer and registered-output flops
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      active_q <= {NUM_PARTS{1'b1}};
      new_q    <= {NUM_PARTS{1'b1}};
      drain_q  <= {NUM_PARTS{1'b0}};
      scrub_q  <= {NUM_PARTS{1'b0}};
      settle_q <= 4'd0;
      ready_q  <= 1'b1;
      stall_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      new_q    <= new_d;
      drain_q  <= drain_d;
      scrub_q  <= scrub_d;
      settle_q <= settle_d;
      ready_q  <= ready_d;
      stall_q  <= stall_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  stq_scrub_walker #(
    .DEPTH        (DEPTH),
    .INDEX        (INDEX),
    .NUM_PARTS    (NUM_PARTS),
    .NUM_PARTS_LOG(NUM_PARTS_LOG)
  ) u_walker (
    .clk         (clk),
    .reset       (reset),
    .start_i     (scrub_start_s),
    .scrub_mask_i(scrub_q),
    .idx_o       (scrub_idx_s),
    .we_o        (scrub_we_s),
    .done_o      (scrub_done_s)
  );

  // CAM write-port mux: dispatch straight through when idle, walker otherwise
  always_comb begin
    disp_part_s = NUM_PARTS_LOG'(partOf(32'(dispAddr_i), INDEX, NUM_PARTS_LOG));
    if (state_q == ST_IDLE) begin
      camWe_o   = dispWe_i & active_q[disp_part_s];
      camAddr_o = dispAddr_i;
      camData_o = dispData_i;
    end else begin
      camWe_o   = scrub_we_s;
      camAddr_o = scrub_idx_s;
      camData_o = scrub_we_s ? SCRUB_TAG[WIDTH-1:0] : {WIDTH{1'b0}};
    end
  end

  assign reqReady_o           = ready_q;
  assign lsqPartitionActive_o = active_q;
  assign stallDispatch_o      = stall_q;
  assign reconfigDone_o       = done_q;
  assign reqError_o           = err_q;

endmodule

// File: tb/tb_stq_partition_reconfig_ctrl.sv
// Self-checking bench for stq_partition_reconfig_ctrl: vector table, directed
// reconfiguration sequences and randomized requests against a schedule model.
module tb_stq_partition_reconfig_ctrl;

  localparam int DEPTH  = 16;
  localparam int INDEX  = 4;
  localparam int WIDTH  = 8;
  localparam int SETTLE = 2;
`ifdef STQ_PART_SCRUB_EN
  localparam int SCRUB_LEN = DEPTH;
  localparam int RST_AT    = 10;
`else
  localparam int SCRUB_LEN = 0;
  localparam int RST_AT    = 1;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             reqValid;
  logic [3:0]       reqMask;
  logic             reqReady_o;
  logic [DEPTH-1:0] stqOccupied;
  logic             dispWe;
  logic [INDEX-1:0] dispAddr;
  logic [WIDTH-1:0] dispData;
  logic             camWe_o;
  logic [INDEX-1:0] camAddr_o;
  logic [WIDTH-1:0] camData_o;
  logic [3:0]       lsqPartitionActive_o;
  logic             stallDispatch_o;
  logic             reconfigDone_o;
  logic             reqError_o;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] act_m;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
    logic       exp_we;
  } vec_t;
  vec_t vt[8];

  always #5 clk = ~clk;

  stq_partition_reconfig_ctrl #(
    .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH),
    .NUM_PARTS(4), .NUM_PARTS_LOG(2), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .reset(reset),
    .reqValid_i(reqValid), .reqMask_i(reqMask), .reqReady_o(reqReady_o),
    .stqOccupied_i(stqOccupied),
    .dispWe_i(dispWe), .dispAddr_i(dispAddr), .dispData_i(dispData),
    .camWe_o(camWe_o), .camAddr_o(camAddr_o), .camData_o(camData_o),
    .lsqPartitionActive_o(lsqPartitionActive_o),
    .stallDispatch_o(stallDispatch_o),
    .reconfigDone_o(reconfigDone_o), .reqError_o(reqError_o)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic disp_chk(input logic we, input logic [3:0] addr, input logic [7:0] data);
    int p;
    p = int'(addr) / 4;
    dispWe = we; dispAddr = addr; dispData = data;
    #1;
    chk("disp_we", camWe_o, we & act_m[p]);
    chk("disp_addr", camAddr_o, addr);
    chk("disp_data", camData_o, data);
    dispWe = 1'b0;
  endtask

  // One request, with stores held in a removed partition for 'hold' cycles.
  task automatic do_req(input logic [3:0] mask, input int hold);
    logic [3:0]  dm, sm;
    logic [15:0] keep_bits, hold_bits;
    int exp_q[$];
    int got_q[$];
    int exp_lat, t, done_t, data_bad, stall_bad, addr_bad, p;
    dm = act_m & ~mask;
    sm = mask & ~act_m;
    keep_bits = 16'($urandom());
    for (int e = 0; e < DEPTH; e++) begin
      if (dm[e/4]) keep_bits[e] = 1'b0;
      if (sm[e/4] && SCRUB_LEN > 0) exp_q.push_back(e);
    end
    hold_bits = keep_bits;
    if (dm != 4'b0000 && hold > 0) begin
      p = 0;
      while (!dm[p]) p++;
      hold_bits[p*4 + int'($urandom_range(0, 3))] = 1'b1;
    end
    stqOccupied = hold_bits; reqMask = mask; reqValid = 1'b1;
    cyc();
    reqValid = 1'b0;
    if (mask == 4'b0000) begin
      chk("err_pulse", reqError_o, 1'b1);
      chk("err_no_stall", stallDispatch_o, 1'b0);
      chk("err_no_done", reconfigDone_o, 1'b0);
      chk("err_mask_kept", lsqPartitionActive_o, act_m);
      cyc();
      chk("err_pulse_end", reqError_o, 1'b0);
    end else if (mask == act_m) begin
      chk("same_done", reconfigDone_o, 1'b1);
      chk("same_no_stall", stallDispatch_o, 1'b0);
      chk("same_no_err", reqError_o, 1'b0);
      cyc();
      chk("same_done_end", reconfigDone_o, 1'b0);
    end else begin
      exp_lat = ((dm != 4'b0000) ? hold : 0) + 1 + SCRUB_LEN + SETTLE;
      done_t = -1; t = 0; data_bad = 0; stall_bad = 0; addr_bad = 0;
      while (done_t < 0 && t <= 200) begin
        if (reconfigDone_o) begin
          done_t = t;
        end else begin
          if (camWe_o) begin
            got_q.push_back(int'(camAddr_o));
            if (camData_o !== 8'hFF) data_bad++;
          end
          if (stallDispatch_o !== 1'b1 || reqReady_o !== 1'b0) stall_bad++;
          stqOccupied = (t + 1 <= hold) ? hold_bits : keep_bits;
          cyc();
          t++;
        end
      end
      chk("done_latency", done_t, exp_lat);
      chk("stall_dropped", stallDispatch_o, 1'b0);
      chk("ready_back", reqReady_o, 1'b1);
      chk("new_mask", lsqPartitionActive_o, mask);
      chk("scrub_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i >= got_q.size() || got_q[i] != exp_q[i]) addr_bad++;
      end
      chk("scrub_addrs_bad", addr_bad, 0);
      chk("scrub_data_bad", data_bad, 0);
      chk("stall_held_bad", stall_bad, 0);
      act_m = mask;
      cyc();
      chk("done_pulse_end", reconfigDone_o, 1'b0);
    end
    stqOccupied = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 4'd0,  8'h11, 1'b1};
    vt[1] = '{1'b1, 4'd7,  8'hA5, 1'b1};
    vt[2] = '{1'b1, 4'd8,  8'h5A, 1'b0};
    vt[3] = '{1'b1, 4'd9,  8'h3C, 1'b0};
    vt[4] = '{1'b1, 4'd15, 8'hFF, 1'b0};
    vt[5] = '{1'b0, 4'd3,  8'h77, 1'b0};
    vt[6] = '{1'b1, 4'd4,  8'h00, 1'b1};
    vt[7] = '{1'b0, 4'd12, 8'h42, 1'b0};

    reset = 1'b0; reqValid = 1'b0; reqMask = 4'h0; stqOccupied = '0;
    dispWe = 1'b0; dispAddr = '0; dispData = '0;
    act_m = 4'b1111;
    repeat (2) cyc();
    chk("rst_ready", reqReady_o, 1'b1);
    chk("rst_active", lsqPartitionActive_o, 4'b1111);
    chk("rst_stall", stallDispatch_o, 1'b0);
    chk("rst_camwe", camWe_o, 1'b0);
    chk("rst_camaddr", camAddr_o, 4'd0);
    chk("rst_camdata", camData_o, 8'd0);
    chk("rst_done", reconfigDone_o, 1'b0);
    chk("rst_err", reqError_o, 1'b0);
    reset = 1'b1;
    cyc();

    disp_chk(1'b1, 4'd5, 8'h3C);
    do_req(4'b0011, 0);
    for (int i = 0; i < 8; i++) begin
      dispWe = vt[i].we; dispAddr = vt[i].addr; dispData = vt[i].data;
      #1;
      chk("vec_we", camWe_o, vt[i].exp_we);
      chk("vec_addr", camAddr_o, vt[i].addr);
      chk("vec_data", camData_o, vt[i].data);
    end
    dispWe = 1'b0;
    cyc();
    do_req(4'b0111, 0);
    do_req(4'b1111, 0);
    do_req(4'b0001, 10);
    do_req(4'b0000, 0);
    do_req(act_m, 0);
    do_req(4'b0011, 0);

    // Reset in the middle of a reconfiguration toward all-active.
    reqMask = 4'b1111; reqValid = 1'b1; stqOccupied = '0;
    cyc();
    reqValid = 1'b0;
    repeat (RST_AT) cyc();
`ifdef STQ_PART_SCRUB_EN
    chk("mid_walker_addr", camAddr_o, 4'd9);
    chk("mid_walker_we", camWe_o, 1'b1);
`endif
    chk("mid_stall", stallDispatch_o, 1'b1);
    reset = 1'b0;
    cyc();
    chk("abort_ready", reqReady_o, 1'b1);
    chk("abort_active", lsqPartitionActive_o, 4'b1111);
    chk("abort_stall", stallDispatch_o, 1'b0);
    chk("abort_camwe", camWe_o, 1'b0);
    chk("abort_done", reconfigDone_o, 1'b0);
    reset = 1'b1;
    act_m = 4'b1111;
    cyc();

    for (int k = 0; k < 25; k++) begin
      logic [3:0] m;
      int r;
      r = int'($urandom_range(0, 7));
      if (r == 0) m = 4'b0000;
      else if (r == 1) m = act_m;
      else m = 4'($urandom_range(1, 15));
      do_req(m, int'($urandom_range(0, 4)));
      for (int j = 0; j < 3; j++) begin
        disp_chk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom()));
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
